// File: rtl/pipe_reg_chain_if.sv
// Producer/consumer handshake bundle for pipe_reg_chain.
//   in_valid, in_data  : producer entry offered to latch 0
//   in_ready           : latch 0 accepts this cycle
//   out_valid, out_data: contents of the last latch
// master = producer/consumer side, slave = the latch chain.
interface pipe_reg_chain_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/pipe_reg_chain.sv
// Parametrised chain of pipeline latches (valid + payload per latch) with
// per-latch stall/flush, automatic upstream hold and downstream bubble
// insertion, and saturating stall/flush/bubble debug counters.
// Ports:
//   clk         : clock, all state on rising edge
//   CLR         : asynchronous active-high reset
//   bus         : handshake bundle (in_valid/in_data/in_ready/out_valid/out_data)
//   stall       : stall[k] requests latch k to hold
//   flush       : flush[k] clears latch k to a bubble
//   cnt_clr     : synchronous clear of all counters
//   stage_valid : valid bit of each latch
//   stage_data  : payload of each latch, latch k at [k*DATA_W +: DATA_W]
//   stall_cnt   : cycles with any stall bit set
//   flush_cnt   : cycles in which a valid entry was flushed
//   bubble_cnt  : cycles in which stall propagation inserted a bubble
module pipe_reg_chain #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       STAGES     = 4,
  parameter int unsigned       CNT_W      = 16,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic                       clk,
  input  logic                       CLR,
  pipe_reg_chain_if.slave            bus,
  input  logic [STAGES-1:0]          stall,
  input  logic [STAGES-1:0]          flush,
  input  logic                       cnt_clr,
  output logic [STAGES-1:0]          stage_valid,
  output logic [STAGES*DATA_W-1:0]   stage_data,
  output logic [CNT_W-1:0]           stall_cnt,
  output logic [CNT_W-1:0]           flush_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);

  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             hold_up;   // hold of the upstream neighbour
  logic [STAGES-1:0]             up_valid;
  logic [STAGES-1:0][DATA_W-1:0] up_data;
  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
  logic                          bubble_any;
  logic                          flush_hit;
  logic                          stall_any;

  // A stall at latch k freezes every latch from 0 up to k.
  always_comb begin
    hold = '0;
    hold[STAGES-1] = stall[STAGES-1];
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      hold[k] = stall[k] | hold[k+1];
    end
  end

  // Upstream source of each latch: the producer for latch 0, else latch k-1.
  always_comb begin
    hold_up     = '0;
    up_valid    = '0;
    up_data     = '0;
    up_valid[0] = bus.in_valid;
    up_data[0]  = bus.in_data;
    for (int k = 1; k < int'(STAGES); k++) begin
      hold_up[k]  = hold[k-1];
      up_valid[k] = valid_q[k-1];
      up_data[k]  = data_q[k-1];
    end
  end

  // Per-latch next state: flush > hold > bubble > load from upstream.
  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    bubble_any = 1'b0;
    for (int k = 0; k < int'(STAGES); k++) begin
      if (flush[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = BUBBLE_VAL;
      end else if (hold[k]) begin
        valid_d[k] = valid_q[k];
        data_d[k]  = data_q[k];
      end else if (hold_up[k]) begin
        valid_d[k] = 1'b0;
        data_d[k]  = BUBBLE_VAL;
        bubble_any = 1'b1;
      end else begin
        valid_d[k] = up_valid[k];
        data_d[k]  = up_data[k];
      end
    end
  end

  assign flush_hit = |(flush & valid_q);
  assign stall_any = |stall;

  // Saturating increment with clear priority.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             clr);
    if (clr)                    return '0;
    else if (inc && cnt != '1)  return cnt + CNT_W'(1);
    else                        return cnt;
  endfunction

  // Latch chain state.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      valid_q <= '0;
      data_q  <= {STAGES{BUBBLE_VAL}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Debug counters.
  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      stall_cnt  <= cnt_next(stall_cnt,  stall_any,  cnt_clr);
      flush_cnt  <= cnt_next(flush_cnt,  flush_hit,  cnt_clr);
      bubble_cnt <= cnt_next(bubble_cnt, bubble_any, cnt_clr);
    end
  end

  // in_ready depends on stall only; all other outputs come straight from flops.
  assign bus.in_ready  = ~hold[0];
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_data  = data_q[STAGES-1];
  assign stage_valid   = valid_q;
  assign stage_data    = data_q;

endmodule
